// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and width helper for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/divider_step.sv
// divider_step: one restoring-division step, shifting the next dividend bit into the partial remainder.
module divider_step #(
  parameter int N = 16
) (
  input  logic [N-1:0] r,
  input  logic [N-1:0] q,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] r_next,
  output logic [N-1:0] q_next
);

  logic [N:0] t;
  logic [N:0] diff;
  logic       ge;

  // Compare on N+1 bits so the bit shifted out of r still counts.
  always_comb begin
    t      = {r, q[N-1]};
    diff   = t - {1'b0, divisor};
    ge     = t >= {1'b0, divisor};
    r_next = ge ? diff[N-1:0] : t[N-1:0];
    q_next = {q[N-2:0], ge};
  end

endmodule

// File: rtl/divider_32by16.sv
// divider_32by16: iterative restoring 2N/N unsigned divider, one quotient bit per clock, valid/ready handshake.
module divider_32by16
  import div_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int CW = clog2(N);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   r_q, r_d, q_q, q_d, dvs_q, dvs_d;
  logic           out_valid_q, out_valid_d, div_zero_q, div_zero_d, overflow_q, overflow_d;
  logic [N-1:0]   r_step, q_step;
  logic [N-1:0]   hi, lo;

  assign hi = dividend[2*N-1:N];
  assign lo = dividend[N-1:0];

  divider_step #(.N(N)) u_step (
    .r      (r_q),
    .q      (q_q),
    .divisor(dvs_q),
    .r_next (r_step),
    .q_next (q_step)
  );

  // r_q/q_q double as the working registers and the result outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    out_valid_d = out_valid_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        dvs_d       = divisor;
        cnt_d       = '0;
        div_zero_d  = divisor == '0;
        overflow_d  = divisor != '0 && hi >= divisor;
        if (divisor == '0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          q_d         = '1;
          r_d         = lo;
        end else if (hi >= divisor) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          q_d         = '1;
          r_d         = '0;
        end else begin
          state_d = ST_CALC;
          r_d     = hi;
          q_d     = lo;
        end
      end
      ST_CALC: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: if (out_ready) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      out_valid_q <= out_valid_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = state_q == ST_IDLE;
  assign out_valid = out_valid_q;
  assign quotient  = q_q;
  assign remainder = r_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_divider_32by16.sv
// tb_divider_32by16: directed and randomized checks of divider_32by16 against an arithmetic reference model.
module tb_divider_32by16;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   dividend = '0;
  logic [15:0]   divisor = '0;
  logic          in_ready, out_valid, div_zero, overflow;
  logic [15:0]   quotient, remainder;

  int checks = 0;
  int errors = 0;

  divider_32by16 #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dz, output logic ov, output int lat);
    longint unsigned qa;
    dz = 1'b0; ov = 1'b0; lat = 1;
    if (b == 0) begin
      q = 16'hFFFF; r = a[15:0]; dz = 1'b1;
    end else begin
      qa = longint'(a) / longint'(b);
      if (qa > 64'hFFFF) begin
        q = 16'hFFFF; r = 16'h0; ov = 1'b1;
      end else begin
        q = qa[15:0]; r = 16'(longint'(a) % longint'(b)); lat = N + 1;
      end
    end
  endtask

  task automatic accept(input logic [31:0] a, input logic [15:0] b);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [15:0] b, input int stall);
    logic [15:0] eq, er;
    logic        edz, eov;
    int          elat, lat;
    model(a, b, eq, er, edz, eov, elat);
    check({tag, ".in_ready"}, in_ready, 1);
    accept(a, b);
    wait_valid(lat);
    check({tag, ".latency"}, lat, elat);
    repeat (stall) begin @(posedge clk); #1; end
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".quot"}, quotient, eq);
    check({tag, ".rem"}, remainder, er);
    check({tag, ".flags"}, {div_zero, overflow}, {edz, eov});
    if (!edz && !eov)
      check({tag, ".invariant"},
            (longint'(quotient) * longint'(b) + longint'(remainder) == longint'(a)) && remainder < b, 1);
    release_result();
  endtask

  initial begin
    logic [15:0] hq, hr;
    logic [31:0] ra;
    logic [15:0] rb;
    int lat;
    #12;
    check("reset.in_ready", in_ready, 1);
    check("reset.outs", {out_valid, quotient, remainder, div_zero, overflow}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("max", 32'hFFFE0001, 16'hFFFF, 0);
    check("max.back_idle", {out_valid, in_ready}, 2'b01);
    do_op("d1000_7", 32'd1000, 16'd7, 2);
    do_op("d120034", 32'h00120034, 16'h1234, 0);
    do_op("divzero", 32'h12345678, 16'h0000, 1);
    do_op("ovf", 32'h00010000, 16'h0001, 0);
    do_op("noovf", 32'h0000FFFF, 16'h0001, 0);
    do_op("after_flag", 32'd100, 16'd9, 0);

    // Stall in DONE while a new request is offered.
    accept(32'd1000, 16'd7);
    wait_valid(lat);
    check("hold.latency", lat, N + 1);
    hq = quotient; hr = remainder;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2); dividend = 32'h00000010; divisor = 16'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold.stable", {out_valid, in_ready, quotient, remainder, div_zero, overflow},
            {1'b1, 1'b0, 16'd142, 16'd6, 1'b0, 1'b0});
    end
    release_result();
    check("hold.released", {out_valid, in_ready}, 2'b01);

    // Abort mid-calculation.
    accept(32'h00120034, 16'h1234);
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort.outs", {out_valid, in_ready, quotient, remainder, div_zero, overflow},
          {1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post_reset", 32'hFFFE0001, 16'hFFFF, 0);

    for (int k = 0; k < 2000; k++) begin
      rb = 16'($urandom_range(1, 16'hFFFF));
      if ($urandom_range(0, 7) == 0) begin
        ra = $urandom;
        if ($urandom_range(0, 3) == 0) rb = 16'd0;
      end else begin
        ra = {16'($urandom_range(0, int'(rb) - 1)), 16'($urandom)};
      end
      do_op("rand", ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
